// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: FSM states, func codes,
// and small decode helpers.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    MULT_MUL    = 2'b00,
    MULT_MULH   = 2'b01,
    MULT_MULHU  = 2'b10,
    MULT_MULHSU = 2'b11
  } mult_func_t;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'b00,
    DIV_DIVU = 2'b01,
    DIV_REM  = 2'b10,
    DIV_REMU = 2'b11
  } div_func_t;

  function automatic logic div_is_rem(input logic [1:0] func);
    return func[1];
  endfunction

  function automatic logic div_is_signed(input logic [1:0] func);
    return ~func[0];
  endfunction

endpackage

// File: rtl/muldiv_special.sv
// Detects RV32M divide corner cases (divide by zero, signed overflow) and
// produces the architecturally defined result so the divider is never started.
module muldiv_special
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [1:0]      func,
  output logic            is_special,
  output logic [XLEN-1:0] special_result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic div_by_zero;
  logic overflow;

  assign div_by_zero = (rs2 == '0);
  assign overflow    = div_is_signed(func) && (rs1 == INT_MIN) && (rs2 == '1);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    is_special     = 1'b0;
    special_result = '0;
    if (div_by_zero) begin
      is_special     = 1'b1;
      special_result = div_is_rem(func) ? rs1 : '1;
    end else if (overflow) begin
      is_special     = 1'b1;
      special_result = div_is_rem(func) ? '0 : INT_MIN;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequences the multi-cycle multiplier/divider for RV32M ops in E, stalls the
// front of the pipe until the result is ready, and drains a unit after a flush.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_mult_E,
  input  logic            start_div_E,
  input  logic [1:0]      mult_func_E,
  input  logic [1:0]      div_func_E,
  input  logic [XLEN-1:0] rs1_E,
  input  logic [XLEN-1:0] rs2_E,
  input  logic            flush_E,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic            mult_start,
  output logic [1:0]      mult_func,
  input  logic            mult_done,
  input  logic [XLEN-1:0] mult_result,
  output logic            div_start,
  output logic [1:0]      div_func,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_result,
  output logic            muldiv_stall,
  output logic            muldiv_valid,
  output logic [XLEN-1:0] muldiv_result,
  output logic            muldiv_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              busy_div;
  logic              accept;
  logic              timeout;
  logic              unit_done;
  logic [XLEN-1:0]   unit_result;
  logic              is_special;
  logic [XLEN-1:0]   special_result;

  muldiv_special #(.XLEN(XLEN)) u_special (
    .rs1            (rs1_E),
    .rs2            (rs2_E),
    .func           (div_func_E),
    .is_special     (is_special),
    .special_result (special_result)
  );

  assign accept      = (start_mult_E || start_div_E) && !flush_E;
  assign timeout     = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // busy_div remembers which unit is in flight, so the other unit's done is ignored
  assign unit_done   = busy_div ? div_done : mult_done;
  assign unit_result = busy_div ? div_result : mult_result;

  assign muldiv_stall = ((state == S_IDLE) && accept)
                     || (state == S_MUL_WAIT) || (state == S_DIV_WAIT)
                     || ((state == S_DRAIN) && (start_mult_E || start_div_E));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      busy_div      <= 1'b0;
      op_a          <= '0;
      op_b          <= '0;
      mult_start    <= 1'b0;
      mult_func     <= '0;
      div_start     <= 1'b0;
      div_func      <= '0;
      muldiv_valid  <= 1'b0;
      muldiv_result <= '0;
      muldiv_err    <= 1'b0;
    end else begin
      // NOTE: state updates use <= only; pulses default low here so they last exactly one cycle.
      mult_start   <= 1'b0;
      div_start    <= 1'b0;
      muldiv_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (accept) begin
            if (start_mult_E) begin
              op_a       <= rs1_E;
              op_b       <= rs2_E;
              mult_func  <= mult_func_E;
              mult_start <= 1'b1;
              busy_div   <= 1'b0;
              state      <= S_MUL_WAIT;
            end else if (is_special) begin
              muldiv_result <= special_result;
              muldiv_valid  <= 1'b1;
              state         <= S_DONE;
            end else begin
              op_a      <= rs1_E;
              op_b      <= rs2_E;
              div_func  <= div_func_E;
              div_start <= 1'b1;
              busy_div  <= 1'b1;
              state     <= S_DIV_WAIT;
            end
          end
        end
        S_MUL_WAIT, S_DIV_WAIT: begin
          cnt <= cnt + 1'b1;
          if (unit_done) begin
            if (flush_E) begin
              state <= S_IDLE;
            end else begin
              muldiv_result <= unit_result;
              muldiv_valid  <= 1'b1;
              state         <= S_DONE;
            end
          end else if (timeout) begin
            muldiv_err <= 1'b1;
            if (flush_E) begin
              state <= S_IDLE;
            end else begin
              muldiv_result <= '0;
              muldiv_valid  <= 1'b1;
              state         <= S_DONE;
            end
          end else if (flush_E) begin
            state <= S_DRAIN;
          end
        end
        S_DONE: state <= S_IDLE;
        S_DRAIN: begin
          cnt <= cnt + 1'b1;
          if (unit_done) begin
            state <= S_IDLE;
          end else if (timeout) begin
            muldiv_err <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized scoreboard bench for muldiv_ctrl with behavioural multiplier and
// divider models and an RV32M arithmetic reference.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int XLEN = 32;
  localparam int TMO  = 8;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_mult_E = 1'b0, start_div_E = 1'b0, flush_E = 1'b0;
  logic [1:0]  mult_func_E = '0, div_func_E = '0;
  logic [31:0] rs1_E = '0, rs2_E = '0;
  logic [31:0] op_a, op_b, mult_result, div_result, muldiv_result;
  logic        mult_start, div_start, mult_done, div_done, div_done_u, stray_div = 1'b0;
  logic [1:0]  mult_func, div_func;
  logic        muldiv_stall, muldiv_valid, muldiv_err;

  assign div_done = div_done_u | stray_div;

  muldiv_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .start_mult_E(start_mult_E), .start_div_E(start_div_E),
    .mult_func_E(mult_func_E), .div_func_E(div_func_E),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .flush_E(flush_E),
    .op_a(op_a), .op_b(op_b),
    .mult_start(mult_start), .mult_func(mult_func),
    .mult_done(mult_done), .mult_result(mult_result),
    .div_start(div_start), .div_func(div_func),
    .div_done(div_done), .div_result(div_result),
    .muldiv_stall(muldiv_stall), .muldiv_valid(muldiv_valid),
    .muldiv_result(muldiv_result), .muldiv_err(muldiv_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0, n_bad = 0;
  int   mult_starts = 0, div_starts = 0, exp_mult_starts = 0, exp_div_starts = 0;
  int   mult_lat = 1, div_lat = 1;
  bit   err_model = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RV32M arithmetic straight from the ISA definition
  function automatic logic [31:0] ref_op(input bit is_mult, input logic [1:0] f,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, ua, sb, ub, p;
    int          ia, ib;
    sa = {{32{a[31]}}, a};
    ua = {32'd0, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    if (is_mult) begin
      case (f)
        MULT_MUL:   begin p = ua * ub; return p[31:0];  end
        MULT_MULH:  begin p = sa * sb; return p[63:32]; end
        MULT_MULHU: begin p = ua * ub; return p[63:32]; end
        default:    begin p = sa * ub; return p[63:32]; end
      endcase
    end
    case (f)
      DIV_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == INT_MIN && b == 32'hFFFF_FFFF) return INT_MIN;
        return 32'(ia / ib);
      end
      DIV_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      DIV_REM: begin
        if (b == 0) return a;
        if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Behavioural multiplier: answers mult_lat cycles after its start pulse (never if < 0)
  initial begin : mult_unit
    int cnt;
    bit prev;
    cnt = 0;
    prev = 1'b0;
    mult_done = 1'b0;
    mult_result = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      mult_done = 1'b0;
      if (rst) begin
        cnt = 0;
        prev = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) mult_done = 1'b1;
        end
        if (mult_start) begin
          mult_starts++;
          check("mult_start one-cycle", prev, 0);
          mult_result = ref_op(1'b1, mult_func, op_a, op_b);
          cnt = (mult_lat < 0) ? 0 : mult_lat;
        end
        prev = mult_start;
      end
    end
  end

  initial begin : div_unit
    int cnt;
    bit prev;
    cnt = 0;
    prev = 1'b0;
    div_done_u = 1'b0;
    div_result = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      div_done_u = 1'b0;
      if (rst) begin
        cnt = 0;
        prev = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) div_done_u = 1'b1;
        end
        if (div_start) begin
          div_starts++;
          check("div_start one-cycle", prev, 0);
          div_result = ref_op(1'b0, div_func, op_a, op_b);
          cnt = (div_lat < 0) ? 0 : div_lat;
        end
        prev = div_start;
      end
    end
  end

  // Monitor: every valid result is matched against the oldest expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && muldiv_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected muldiv_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("muldiv_result", muldiv_result, e.result);
          check("muldiv_err", muldiv_err, e.err);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive_op(input bit m, input logic [1:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int lat, output int exp_stalls);
    exp_t e;
    bit   special;
    special = !m && (b == 0 || (f[0] == 1'b0 && a == INT_MIN && b == 32'hFFFF_FFFF));
    start_mult_E = m;
    start_div_E  = !m;
    mult_func_E  = f;
    div_func_E   = f;
    rs1_E        = a;
    rs2_E        = b;
    if (m) begin
      mult_lat = lat;
      exp_mult_starts++;
    end else if (!special) begin
      div_lat = lat;
      exp_div_starts++;
    end
    if (lat < 0 && !special) begin
      err_model = 1'b1;
      e.result  = 32'd0;
    end else begin
      e.result = ref_op(m, f, a, b);
    end
    e.err = err_model;
    exp_q.push_back(e);
    exp_stalls = special ? 1 : (lat < 0 ? TMO + 1 : lat + 2);
  endtask

  task automatic finish_op(input string name, input int exp_stalls);
    int stalls, cyc;
    stalls = 0;
    cyc = 0;
    #1;
    while (!muldiv_valid && cyc < 100) begin
      if (muldiv_stall) stalls++;
      @(negedge clk);
      #1;
      cyc++;
    end
    check({name, " completes"}, cyc < 100, 1);
    if (exp_stalls >= 0) check({name, " stall cycles"}, stalls, exp_stalls);
    check({name, " no stall in DONE"}, muldiv_stall, 0);
    @(negedge clk);
    start_mult_E = 1'b0;
    start_div_E  = 1'b0;
  endtask

  initial begin : stimulus
    int es, cyc;
    bit seen_valid;

    repeat (3) @(negedge clk);
    check("reset op_a", op_a, 0);
    check("reset muldiv_result", muldiv_result, 0);
    check("reset valid/err/starts", {muldiv_valid, muldiv_err, mult_start, div_start}, 0);
    check("reset stall", muldiv_stall, 0);
    rst = 1'b0;
    @(negedge clk);

    drive_op(1'b1, MULT_MUL, 32'd7, 32'd6, 3, es);
    finish_op("mul 7*6", es);
    drive_op(1'b0, DIV_DIVU, 32'd100, 32'd0, 2, es);
    finish_op("divu by zero", es);
    drive_op(1'b0, DIV_REMU, 32'd100, 32'd0, 2, es);
    finish_op("remu by zero", es);
    drive_op(1'b0, DIV_DIV, INT_MIN, 32'hFFFF_FFFF, 2, es);
    finish_op("div overflow", es);
    drive_op(1'b0, DIV_REM, INT_MIN, 32'hFFFF_FFFF, 2, es);
    finish_op("rem overflow", es);
    drive_op(1'b0, DIV_DIVU, INT_MIN, 32'hFFFF_FFFF, 2, es);
    finish_op("divu no overflow", es);

    // A divider done while the multiplier is busy must not complete the multiply
    drive_op(1'b1, MULT_MUL, 32'd1234, 32'd5678, 4, es);
    @(negedge clk);
    @(negedge clk);
    stray_div = 1'b1;
    @(negedge clk);
    stray_div = 1'b0;
    finish_op("stray div_done", -1);

    for (int i = 0; i < 40; i++) begin
      bit m;
      logic [1:0] f;
      logic [31:0] a, b;
      int sel;
      m   = 1'($urandom_range(0, 1));
      f   = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = int'($urandom_range(0, 9));
      if (sel < 2) begin
        b = 32'd0;
      end else if (sel == 2) begin
        a = INT_MIN;
        b = 32'hFFFF_FFFF;
      end else if (sel < 5) begin
        a = $urandom_range(0, 200);
        b = $urandom_range(1, 15);
      end
      drive_op(m, f, a, b, int'($urandom_range(1, 5)), es);
      finish_op("random op", es);
    end

    // Flush two cycles after div_start: divider result is discarded, next mul waits
    start_div_E = 1'b1;
    div_func_E  = DIV_DIV;
    rs1_E       = 32'd20;
    rs2_E       = 32'd3;
    div_lat     = 4;
    exp_div_starts++;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!div_start && cyc < 20);
    check("drain div_start issued", div_start, 1);
    @(negedge clk);
    @(negedge clk);
    flush_E     = 1'b1;
    start_div_E = 1'b0;
    @(negedge clk);
    flush_E = 1'b0;
    drive_op(1'b1, MULT_MUL, 32'd7, 32'd6, 3, es);
    #1;
    check("drain stalls new mul", muldiv_stall, 1);
    check("drain holds off mult_start", mult_start, 0);
    finish_op("mul after drain", -1);

    drive_op(1'b1, MULT_MULH, $urandom, $urandom, -1, es);
    finish_op("mul timeout", es);
    repeat (3) @(negedge clk);
    check("err sticky", muldiv_err, 1);
    drive_op(1'b1, MULT_MULHSU, 32'hFFFF_FFF0, 32'd3, 2, es);
    finish_op("mul after timeout", es);

    // Asynchronous reset in the middle of a divide
    start_div_E = 1'b1;
    div_func_E  = DIV_DIVU;
    rs1_E       = 32'd100;
    rs2_E       = 32'd7;
    div_lat     = -1;
    exp_div_starts++;
    repeat (4) @(negedge clk);
    #2;
    rst         = 1'b1;
    start_div_E = 1'b0;
    #1;
    check("async reset op_a/op_b", {op_a, op_b}, 0);
    check("async reset result", muldiv_result, 0);
    check("async reset flags", {muldiv_err, muldiv_valid, div_start, div_func, muldiv_stall}, 0);
    err_model = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stray_div = 1'b1;
    @(negedge clk);
    stray_div = 1'b0;
    seen_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (muldiv_valid) seen_valid = 1'b1;
    end
    check("late div_done ignored", seen_valid, 0);
    drive_op(1'b0, DIV_REM, 32'hFFFF_FF9C, 32'd7, 3, es);
    finish_op("rem after reset", es);

    repeat (3) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    check("mult_start pulses", mult_starts, exp_mult_starts);
    check("div_start pulses", div_starts, exp_div_starts);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
